fp_cvt_seq: RTL and testbench

FP_CVT_SEQ -- requirements
Module: fp_cvt_seq

---
 rtl/fp_cvt_seq.sv | 201 ++++++++++++++++++++
 tb/tb_fp_cvt_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_cvt_seq.sv
// Two-requester front end for a shared FP converter: round-robin arbitration,
// f2i results taken straight from the converter, f2f/i2f results from a handshaked rounder.
module fp_cvt_seq #(
    parameter int RND_TIMEOUT = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [3:0]   req_kind,
    input  logic [129:0] req_data,
    input  logic [3:0]   req_op,
    input  logic [3:0]   req_fmt,
    input  logic [5:0]   req_rm,
    input  logic [19:0]  req_class,
    output logic [64:0]  cvt_data,
    output logic [1:0]   cvt_op,
    output logic [1:0]   cvt_fmt,
    output logic [2:0]   cvt_rm,
    output logic [9:0]   cvt_class,
    output logic [1:0]   cvt_kind,
    input  logic [63:0]  cvt_result,
    input  logic [4:0]   cvt_flags,
    output logic         rnd_req,
    input  logic         rnd_ack,
    input  logic [63:0]  rnd_result,
    input  logic [4:0]   rnd_flags,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [63:0]  res_data,
    output logic [4:0]   res_flags,
    output logic         res_id
);

    typedef enum logic [1:0] {IDLE, CVT, RND, DONE} state_t;

    localparam logic [1:0] KIND_F2I = 2'd1;
    localparam logic [1:0] KIND_ILL = 2'd3;
    localparam logic [4:0] ERR_FLAGS = 5'b10000;

    state_t       state_reg, state_next;
    logic         last_reg;
    logic [7:0]   cnt_reg;
    logic [1:0]   kind_reg;
    logic [64:0]  data_reg;
    logic [1:0]   op_reg;
    logic [1:0]   fmt_reg;
    logic [2:0]   rm_reg;
    logic [9:0]   class_reg;
    logic         id_reg;
    logic [63:0]  res_data_reg;
    logic [4:0]   res_flags_reg;

    logic [1:0]   kind_arr  [2];
    logic [64:0]  data_arr  [2];
    logic [1:0]   op_arr    [2];
    logic [1:0]   fmt_arr   [2];
    logic [2:0]   rm_arr    [2];
    logic [9:0]   class_arr [2];

    logic [1:0]   grant;
    logic         win_id;
    logic         idle_ok;
    logic         accept;
    logic         load_op, cap_cvt, cap_rnd, cap_err, cnt_clr, cnt_inc;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign kind_arr[gi]  = req_kind[gi*2 +: 2];
            assign data_arr[gi]  = req_data[gi*65 +: 65];
            assign op_arr[gi]    = req_op[gi*2 +: 2];
            assign fmt_arr[gi]   = req_fmt[gi*2 +: 2];
            assign rm_arr[gi]    = req_rm[gi*3 +: 3];
            assign class_arr[gi] = req_class[gi*10 +: 10];
        end
    endgenerate

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        if (req_valid == 2'b11) grant = last_reg ? 2'b01 : 2'b10;
        else                    grant = req_valid;
    end

    assign win_id    = grant[1];
    assign idle_ok   = (state_reg == IDLE) && !flush && !reset;
    assign req_ready = idle_ok ? grant : 2'b00;
    assign accept    = idle_ok && (grant != 2'b00);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load_op    = 1'b0;
        cap_cvt    = 1'b0;
        cap_rnd    = 1'b0;
        cap_err    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    load_op    = 1'b1;
                    state_next = CVT;
                end
            end
            CVT: begin
                if (kind_reg == KIND_F2I) begin
                    cap_cvt    = 1'b1;
                    state_next = DONE;
                end else if (kind_reg == KIND_ILL) begin
                    cap_err    = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_clr    = 1'b1;
                    state_next = RND;
                end
            end
            RND: begin
                if (rnd_ack) begin
                    cap_rnd    = 1'b1;
                    state_next = DONE;
                end else if (cnt_reg == 8'(RND_TIMEOUT - 1)) begin
                    cap_err    = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_inc    = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Abort wins over everything, including a same-cycle ack or drain.
        if (flush) begin
            state_next = IDLE;
            load_op    = 1'b0;
            cap_cvt    = 1'b0;
            cap_rnd    = 1'b0;
            cap_err    = 1'b0;
            cnt_clr    = 1'b0;
            cnt_inc    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_reg      <= 1'b1;
            cnt_reg       <= '0;
            kind_reg      <= '0;
            data_reg      <= '0;
            op_reg        <= '0;
            fmt_reg       <= '0;
            rm_reg        <= '0;
            class_reg     <= '0;
            id_reg        <= 1'b0;
            res_data_reg  <= '0;
            res_flags_reg <= '0;
        end else begin
            if (load_op) begin
                kind_reg  <= kind_arr[win_id];
                data_reg  <= data_arr[win_id];
                op_reg    <= op_arr[win_id];
                fmt_reg   <= fmt_arr[win_id];
                rm_reg    <= rm_arr[win_id];
                class_reg <= class_arr[win_id];
                id_reg    <= win_id;
                last_reg  <= win_id;
            end
            if (cnt_clr)      cnt_reg <= '0;
            else if (cnt_inc) cnt_reg <= cnt_reg + 8'd1;
            if (cap_cvt) begin
                res_data_reg  <= cvt_result;
                res_flags_reg <= cvt_flags;
            end else if (cap_rnd) begin
                res_data_reg  <= rnd_result;
                res_flags_reg <= rnd_flags;
            end else if (cap_err) begin
                res_data_reg  <= '0;
                res_flags_reg <= ERR_FLAGS;
            end
        end
    end

    assign cvt_data  = data_reg;
    assign cvt_op    = op_reg;
    assign cvt_fmt   = fmt_reg;
    assign cvt_rm    = rm_reg;
    assign cvt_class = class_reg;
    assign cvt_kind  = kind_reg;
    assign rnd_req   = (state_reg == RND) && !flush;
    assign res_valid = (state_reg == DONE) && !flush;
    assign res_data  = res_data_reg;
    assign res_flags = res_flags_reg;
    assign res_id    = id_reg;

endmodule

// File: tb/tb_fp_cvt_seq.sv
// Randomized and directed checks of fp_cvt_seq against a transaction-level model
// of arbitration, result selection, rounder timeout and latency.
module tb_fp_cvt_seq;

    localparam int TMO = 16;

    logic         clock = 1'b0;
    logic         reset, flush;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [3:0]   req_kind;
    logic [129:0] req_data;
    logic [3:0]   req_op, req_fmt;
    logic [5:0]   req_rm;
    logic [19:0]  req_class;
    logic [64:0]  cvt_data;
    logic [1:0]   cvt_op, cvt_fmt, cvt_kind;
    logic [2:0]   cvt_rm;
    logic [9:0]   cvt_class;
    logic [63:0]  cvt_result;
    logic [4:0]   cvt_flags;
    logic         rnd_req, rnd_ack;
    logic [63:0]  rnd_result;
    logic [4:0]   rnd_flags;
    logic         res_valid, res_ready;
    logic [63:0]  res_data;
    logic [4:0]   res_flags;
    logic         res_id;

    logic [1:0]   kind_s  [2];
    logic [64:0]  data_s  [2];
    logic [1:0]   op_s    [2];
    logic [1:0]   fmt_s   [2];
    logic [2:0]   rm_s    [2];
    logic [9:0]   class_s [2];
    logic [63:0]  rnd_val;
    logic [4:0]   rnd_fl;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;
    bit mdl_last;

    assign req_kind  = {kind_s[1], kind_s[0]};
    assign req_data  = {data_s[1], data_s[0]};
    assign req_op    = {op_s[1], op_s[0]};
    assign req_fmt   = {fmt_s[1], fmt_s[0]};
    assign req_rm    = {rm_s[1], rm_s[0]};
    assign req_class = {class_s[1], class_s[0]};

    // Converter stand-in: result depends on every operand field.
    assign cvt_result = cvt_data[63:0] ^ {54'b0, cvt_class} ^ {61'b0, cvt_rm};
    assign cvt_flags  = {cvt_op, cvt_fmt, cvt_data[64]};
    assign rnd_result = rnd_val;
    assign rnd_flags  = rnd_fl;

    fp_cvt_seq #(.RND_TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_data(req_data), .req_op(req_op), .req_fmt(req_fmt),
        .req_rm(req_rm), .req_class(req_class),
        .cvt_data(cvt_data), .cvt_op(cvt_op), .cvt_fmt(cvt_fmt),
        .cvt_rm(cvt_rm), .cvt_class(cvt_class), .cvt_kind(cvt_kind),
        .cvt_result(cvt_result), .cvt_flags(cvt_flags),
        .rnd_req(rnd_req), .rnd_ack(rnd_ack), .rnd_result(rnd_result),
        .rnd_flags(rnd_flags),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_flags(res_flags), .res_id(res_id)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] f2i_ref(input bit id);
        return data_s[id][63:0] ^ {54'b0, class_s[id]} ^ {61'b0, rm_s[id]};
    endfunction

    function automatic logic [4:0] f2i_flags_ref(input bit id);
        return {op_s[id], fmt_s[id], data_s[id][64]};
    endfunction

    task automatic rand_fields(input bit id, input logic [1:0] k);
        kind_s[id]  = k;
        data_s[id]  = {1'($urandom_range(0, 1)), $urandom(), $urandom()};
        op_s[id]    = 2'($urandom_range(0, 3));
        fmt_s[id]   = 2'($urandom_range(0, 3));
        rm_s[id]    = 3'($urandom_range(0, 7));
        class_s[id] = 10'($urandom_range(0, 1023));
    endtask

    // Entered mid-cycle in IDLE with req_valid already driven; leaves mid-cycle in IDLE.
    // ack_at: RND cycle on which rnd_ack is raised (0 = never). hold: DONE cycles with res_ready low.
    task automatic run_txn(input int ack_at, input int hold);
        bit          id;
        logic [1:0]  k;
        logic [63:0] exp_d;
        logic [4:0]  exp_f;
        int          n;
        bit          acked;
        id    = (req_valid == 2'b11) ? ~mdl_last : req_valid[1];
        k     = kind_s[id];
        acked = (ack_at >= 1) && (ack_at <= TMO);
        #1;
        check("req_ready", 128'(req_ready), 128'(id ? 2'b10 : 2'b01));
        mdl_last = id;
        if (k == 2'd1) begin
            exp_d = f2i_ref(id);
            exp_f = f2i_flags_ref(id);
        end else if (k == 2'd3 || !acked) begin
            exp_d = 64'd0;
            exp_f = 5'b10000;
        end else begin
            exp_d = rnd_val;
            exp_f = rnd_fl;
        end
        @(posedge clock); #1;
        check("cvt_kind", 128'(cvt_kind), 128'(k));
        check("cvt_data", 128'(cvt_data), 128'(data_s[id]));
        check("busy_ready", 128'(req_ready), 128'(0));
        check("cvt_no_rnd", 128'(rnd_req), 128'(0));
        check("cvt_no_valid", 128'(res_valid), 128'(0));
        n = 0;
        @(posedge clock); #1;
        if (k == 2'd0 || k == 2'd2) begin
            while (rnd_req && n < 4 * TMO) begin
                n++;
                rnd_ack = (n == ack_at);
                @(posedge clock); #1;
                rnd_ack = 1'b0;
            end
            check("rnd_cycles", 128'(n), 128'(acked ? ack_at : TMO));
        end
        check("res_valid", 128'(res_valid), 128'(1));
        check("res_data", 128'(res_data), 128'(exp_d));
        check("res_flags", 128'(res_flags), 128'(exp_f));
        check("res_id", 128'(res_id), 128'(id));
        check("done_no_rnd", 128'(rnd_req), 128'(0));
        check("cvt_hold", 128'({cvt_rm, cvt_class, cvt_data}), 128'({rm_s[id], class_s[id], data_s[id]}));
        res_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            check("hold_valid", 128'(res_valid), 128'(1));
            check("hold_data", 128'(res_data), 128'(exp_d));
            check("hold_flags", 128'(res_flags), 128'(exp_f));
            check("hold_id", 128'(res_id), 128'(id));
            check("hold_ready", 128'(req_ready), 128'(0));
        end
        res_ready = 1'b1;
        #1;
        check("done_ready", 128'(req_ready), 128'(0));
        @(posedge clock); #1;
        check("res_drop", 128'(res_valid), 128'(0));
        txn_no++;
        $display("txn %0d: id=%0d kind=%0d rnd_cycles=%0d res_data=%h res_flags=%b",
                 txn_no, id, k, n, exp_d, exp_f);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; rnd_ack = 1'b0; res_ready = 1'b1;
        rnd_val = '0; rnd_fl = '0;
        for (int i = 0; i < 2; i++) begin
            kind_s[i] = '0; data_s[i] = '0; op_s[i] = '0;
            fmt_s[i] = '0; rm_s[i] = '0; class_s[i] = '0;
        end
        req_valid = 2'b11;
        mdl_last  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_rnd_req", 128'(rnd_req), 128'(0));
        check("rst_res_valid", 128'(res_valid), 128'(0));
        check("rst_res_data", 128'(res_data), 128'(0));
        check("rst_res_flags", 128'(res_flags), 128'(0));
        check("rst_res_id", 128'(res_id), 128'(0));
        check("rst_cvt", 128'({cvt_data, cvt_op, cvt_fmt, cvt_rm, cvt_class, cvt_kind}), 128'(0));
        reset = 1'b0;

        // Both requesters valid back to back: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            rand_fields(0, 2'd1);
            rand_fields(1, 2'd1);
            run_txn(0, 0);
            check("alternate_id", 128'(res_id), 128'(i % 2));
        end

        // f2i with a known converter result of 0x2A, no flags.
        req_valid = 2'b01;
        kind_s[0] = 2'd1; data_s[0] = 65'h2A; op_s[0] = '0; fmt_s[0] = '0; rm_s[0] = '0; class_s[0] = '0;
        run_txn(0, 0);

        // i2f with rounder answering on the 5th request cycle.
        req_valid = 2'b10;
        rand_fields(1, 2'd2);
        rnd_val = 64'h3F80_0000; rnd_fl = 5'b0;
        run_txn(5, 0);

        // f2f with the rounder silent: timeout after TMO cycles.
        req_valid = 2'b01;
        rand_fields(0, 2'd0);
        run_txn(0, 0);

        // Ack on the final allowed cycle still wins over the timeout.
        rand_fields(0, 2'd2);
        rnd_val = 64'hDEAD_BEEF_0123_4567; rnd_fl = 5'b00101;
        run_txn(TMO, 0);

        // Illegal kind, result held while the consumer stalls 4 cycles.
        req_valid = 2'b11;
        rand_fields(0, 2'd3);
        rand_fields(1, 2'd3);
        run_txn(0, 4);

        // Flush: blocks grant in IDLE, then aborts RND despite a same-cycle ack.
        req_valid = 2'b01;
        rand_fields(0, 2'd2);
        flush = 1'b1;
        #1;
        check("flush_gate", 128'(req_ready), 128'(0));
        flush = 1'b0;
        #1;
        check("flush_pre_ready", 128'(req_ready), 128'(2'b01));
        mdl_last = 1'b0;
        @(posedge clock); #1;
        req_valid = 2'b00;
        @(posedge clock); #1;
        check("flush_rnd_on", 128'(rnd_req), 128'(1));
        @(posedge clock); #1;
        flush = 1'b1; rnd_ack = 1'b1;
        #1;
        check("flush_rnd_gate", 128'(rnd_req), 128'(0));
        check("flush_valid_gate", 128'(res_valid), 128'(0));
        @(posedge clock); #1;
        flush = 1'b0; rnd_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("flush_no_valid", 128'(res_valid), 128'(0));
            check("flush_no_rnd", 128'(rnd_req), 128'(0));
            @(posedge clock); #1;
        end
        req_valid = 2'b11;
        rand_fields(0, 2'd1);
        rand_fields(1, 2'd1);
        run_txn(0, 0);

        // Reset mid-operation restores the pointer so requester 0 wins the next tie.
        req_valid = 2'b01;
        rand_fields(0, 2'd2);
        #1;
        check("rstmid_ready", 128'(req_ready), 128'(2'b01));
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("rstmid_rnd", 128'(rnd_req), 128'(0));
        check("rstmid_valid", 128'(res_valid), 128'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        mdl_last = 1'b1;
        req_valid = 2'b11;
        rand_fields(0, 2'd1);
        rand_fields(1, 2'd1);
        run_txn(0, 0);

        // Random mix of requesters, kinds, rounder delays and consumer stalls.
        for (int i = 0; i < 40; i++) begin
            req_valid = 2'($urandom_range(1, 3));
            rand_fields(0, 2'($urandom_range(0, 3)));
            rand_fields(1, 2'($urandom_range(0, 3)));
            rnd_val = {$urandom(), $urandom()};
            rnd_fl  = 5'($urandom_range(0, 31));
            run_txn(int'($urandom_range(0, 20)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
